// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich simulation sequencer:
// sequencer state encoding and default sizing constants.
package izh_pkg;

    localparam int DEF_LANES   = 4;
    localparam int DEF_N_W     = 10;
    localparam int DEF_TS_W    = 10;
    localparam int DEF_MAX_OUT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_STEP  = 3'd3,
        ST_ABORT = 3'd4,
        ST_DONE  = 3'd5
    } izh_state_t;

endpackage

// File: rtl/izh_sim_seq_if.sv
// Request/return channel between the sequencer (master) and the
// neuron update pipeline (slave).
interface izh_sim_seq_if
    import izh_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int N_W   = DEF_N_W
);

    logic             issue_valid;
    logic             issue_ready;
    logic [N_W-1:0]   issue_base;
    logic [LANES-1:0] issue_mask;
    logic             done_valid;
    logic [LANES-1:0] done_spikes;

    modport master (
        output issue_valid, issue_base, issue_mask,
        input  issue_ready, done_valid, done_spikes
    );

    modport slave (
        input  issue_valid, issue_base, issue_mask,
        output issue_ready, done_valid, done_spikes
    );

endinterface

// File: rtl/izh_mask_fifo.sv
// Small FIFO remembering the lane mask of every issued group so the
// returned spike flags can be qualified in issue order.
module izh_mask_fifo
    import izh_pkg::*;
#(
    parameter int WIDTH = DEF_LANES,
    parameter int DEPTH = DEF_MAX_OUT
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);

    // Mask storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Read/write pointers (wrap at DEPTH, which need not be a power of two) and occupancy.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rptr];
    assign full = (count == FULL_CNT);

endmodule

// File: rtl/izh_sim_seq.sv
// Simulation sequencer: walks the neuron array in LANES-wide groups for
// each timestep, bounds the number of groups in flight, totals the spikes
// returned by the update pipeline and reports one sum per timestep.
module izh_sim_seq
    import izh_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int N_W     = DEF_N_W,
    parameter int TS_W    = DEF_TS_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic            clk,
    input  logic            aclr,
    input  logic            start,
    input  logic            abort,
    input  logic [N_W-1:0]  size,
    input  logic [TS_W-1:0] timesteps,
    izh_sim_seq_if.master   bus,
    output logic            busy,
    output logic            finished,
    output logic [TS_W-1:0] cur_timestep,
    output logic            ts_valid,
    output logic [N_W:0]    ts_spikes,
    output logic            err
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
    localparam logic [N_W:0]  LANES_C   = (N_W + 1)'(LANES);

    izh_state_t       state;
    logic [N_W-1:0]   size_r;
    logic [TS_W-1:0]  ts_r;
    logic [N_W-1:0]   base;
    logic [N_W:0]     base_nxt;
    logic [OW-1:0]    outst;
    logic [OW-1:0]    outst_nxt;
    logic [N_W:0]     acc;
    logic [N_W:0]     acc_nxt;
    logic [LANES-1:0] mask;
    logic [LANES-1:0] fifo_head;
    logic             fifo_full;
    logic             can_issue;
    logic             xfer;
    logic             ret;
    logic             stray;

    // Number of set bits in a lane vector, sized to the accumulator.
    function automatic logic [N_W:0] popcount(input logic [LANES-1:0] v);
        logic [N_W:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + (N_W + 1)'(v[i]);
        end
        return c;
    endfunction

    // Lane i is live while its neuron index is inside the captured size.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mask[i] = (({1'b0, base} + (N_W + 1)'(i)) < {1'b0, size_r});
        end
    end

    assign can_issue = (state == ST_ISSUE) && (outst < MAX_OUT_C) && !fifo_full;
    assign xfer      = can_issue && bus.issue_ready;
    // A result with nothing outstanding is a protocol error and is not counted.
    assign ret       = bus.done_valid && (outst != '0);
    assign stray     = bus.done_valid && (outst == '0);
    assign base_nxt  = {1'b0, base} + LANES_C;
    assign acc_nxt   = acc + (ret ? popcount(bus.done_spikes & fifo_head) : '0);

    // Outstanding count: simultaneous issue and return cancel out.
    always_comb begin
        outst_nxt = outst;
        case ({xfer, ret})
            2'b10:   outst_nxt = outst + 1'b1;
            2'b01:   outst_nxt = outst - 1'b1;
            default: outst_nxt = outst;
        endcase
    end

    izh_mask_fifo #(
        .WIDTH (LANES),
        .DEPTH (MAX_OUT)
    ) u_mask_fifo (
        .clk  (clk),
        .aclr (aclr),
        .push (xfer),
        .din  (mask),
        .pop  (ret),
        .dout (fifo_head),
        .full (fifo_full)
    );

    // Sequencer FSM with its counters, accumulator and per-timestep report.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state        <= ST_IDLE;
            size_r       <= '0;
            ts_r         <= '0;
            base         <= '0;
            cur_timestep <= '0;
            outst        <= '0;
            acc          <= '0;
            ts_valid     <= 1'b0;
            ts_spikes    <= '0;
        end else begin
            outst    <= outst_nxt;
            acc      <= acc_nxt;
            ts_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        size_r       <= size;
                        ts_r         <= timesteps;
                        cur_timestep <= '0;
                        base         <= '0;
                        acc          <= '0;
                        state        <= ((size == '0) || (timesteps == '0)) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state <= ST_ABORT;
                    end else if (xfer) begin
                        base <= base_nxt[N_W-1:0];
                        if (base_nxt >= {1'b0, size_r}) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Enter STEP on the same edge that retires the last result.
                    if (abort) begin
                        state <= ST_ABORT;
                    end else if (outst_nxt == '0) begin
                        state     <= ST_STEP;
                        ts_valid  <= 1'b1;
                        ts_spikes <= acc_nxt;
                    end
                end
                ST_STEP: begin
                    acc <= '0;
                    if (abort) begin
                        state <= ST_ABORT;
                    end else if (cur_timestep == ts_r - 1'b1) begin
                        state <= ST_DONE;
                    end else begin
                        cur_timestep <= cur_timestep + 1'b1;
                        base         <= '0;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ABORT: begin
                    if (outst_nxt == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flag for results returned with nothing in flight.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            err <= 1'b0;
        end else if (stray) begin
            err <= 1'b1;
        end
    end

    assign bus.issue_valid = can_issue;
    assign bus.issue_base  = base;
    assign bus.issue_mask  = mask;
    assign busy            = (state != ST_IDLE) && (state != ST_DONE);
    assign finished        = (state == ST_DONE);

endmodule

// File: tb/tb_izh_sim_seq.sv
// Bench for izh_sim_seq: table of whole simulations plus random runs
// against a group-level reference model, then hand sequences for
// back-pressure, abort, error flag and asynchronous reset.
module tb_izh_sim_seq;
    import izh_pkg::*;

    localparam int LANES = 4;
    localparam int N_W   = 10;
    localparam int TS_W  = 10;
    localparam int MO    = 2;

    logic            clk = 1'b0;
    logic            aclr;
    logic            start;
    logic            abort;
    logic [N_W-1:0]  size;
    logic [TS_W-1:0] timesteps;
    logic            busy;
    logic            finished;
    logic [TS_W-1:0] cur_timestep;
    logic            ts_valid;
    logic [N_W:0]    ts_spikes;
    logic            err;

    int n_cmp  = 0;
    int n_bad  = 0;
    int ts_cnt = 0;

    izh_sim_seq_if #(.LANES(LANES), .N_W(N_W)) bus ();

    izh_sim_seq #(
        .LANES   (LANES),
        .N_W     (N_W),
        .TS_W    (TS_W),
        .MAX_OUT (MO)
    ) dut (
        .clk          (clk),
        .aclr         (aclr),
        .start        (start),
        .abort        (abort),
        .size         (size),
        .timesteps    (timesteps),
        .bus          (bus),
        .busy         (busy),
        .finished     (finished),
        .cur_timestep (cur_timestep),
        .ts_valid     (ts_valid),
        .ts_spikes    (ts_spikes),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ts_valid) ts_cnt <= ts_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int sz;
        int nts;
        int ones;
        int rdy;
        int lat;
        int groups;
        int steps;
        int spk;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] lane_mask(input int b, input int sz);
        logic [3:0] r;
        for (int i = 0; i < LANES; i++) r[i] = ((b + i) < sz);
        return r;
    endfunction

    // One full simulation from IDLE/DONE; the model tracks issue position,
    // groups in flight and expected per-step spike totals.
    task automatic run_sim(input vec_t v);
        int cyc = 0, groups = 0, steps = 0, exp_base = 0, outst = 0;
        int sum = 0, last_due = 0, due, ts0;
        logic [3:0] s, m, head;
        logic [3:0] spk_q[$];
        int due_q[$];
        bit exp_iv, exp_tsv, rdy, dv;
        ts0 = ts_cnt;
        m = '0;
        head = '0;
        size = v.sz[N_W-1:0];
        timesteps = v.nts[TS_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        size = N_W'($urandom);
        timesteps = TS_W'($urandom);
        if (v.sz == 0 || v.nts == 0) begin
            chk("degen_finished", finished, 1);
            chk("degen_busy", busy, 0);
            repeat (3) begin
                chk("degen_issue_valid", bus.issue_valid, 0);
                tick();
            end
            chk("degen_ts_pulses", ts_cnt - ts0, 0);
            chk("degen_still_done", finished, 1);
            return;
        end
        chk("first_issue", bus.issue_valid, 1);
        while (!finished && cyc < 20000) begin
            exp_tsv = (exp_base >= v.sz) && (outst == 0) && (steps < v.nts);
            chk("ts_valid", ts_valid, exp_tsv);
            if (exp_tsv) begin
                chk("ts_spikes", ts_spikes, (v.ones != 0) ? v.spk : sum);
                chk("ts_index", cur_timestep, steps);
                steps++;
                sum = 0;
                exp_base = (steps < v.nts) ? 0 : v.sz;
            end
            exp_iv = (exp_base < v.sz) && (outst < MO) && !exp_tsv;
            chk("issue_valid", bus.issue_valid, exp_iv);
            if (exp_iv) begin
                m = lane_mask(exp_base, v.sz);
                chk("issue_base", bus.issue_base, exp_base);
                chk("issue_mask", bus.issue_mask, m);
            end
            chk("busy_run", busy, 1);
            rdy = ($urandom_range(99) < v.rdy);
            dv = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                dv = 1'b1;
                head = spk_q.pop_front();
                void'(due_q.pop_front());
                outst--;
            end
            bus.issue_ready = rdy;
            bus.done_valid = dv;
            bus.done_spikes = dv ? head : 4'($urandom);
            start = ($urandom_range(7) == 0);
            if (exp_iv && rdy) begin
                s = (v.ones != 0) ? 4'hF : 4'($urandom);
                sum += $countones(s & m);
                spk_q.push_back(s);
                due = cyc + $urandom_range(v.lat, 1);
                if (due < last_due) due = last_due;
                last_due = due;
                due_q.push_back(due);
                exp_base += LANES;
                outst++;
                groups++;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        bus.issue_ready = 1'b0;
        bus.done_valid = 1'b0;
        chk("finished", finished, 1);
        chk("busy_done", busy, 0);
        chk("steps", steps, v.steps);
        chk("groups", groups, v.groups);
        chk("ts_pulses", ts_cnt - ts0, v.steps);
        chk("last_timestep", cur_timestep, v.nts - 1);
        chk("err_clean", err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ignored_done", finished, 1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", finished, 1);
        chk("abort_beats_start_busy", busy, 0);
    endtask

    vec_t tbl[8];
    vec_t rv;
    int   ts0;

    initial begin
        aclr = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        size = '0;
        timesteps = '0;
        bus.issue_ready = 1'b0;
        bus.done_valid = 1'b0;
        bus.done_spikes = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        chk("rst_issue_valid", bus.issue_valid, 0);
        chk("rst_ts_valid", ts_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_timestep", cur_timestep, 0);
        chk("rst_base", bus.issue_base, 0);
        aclr = 1'b0;
        tick();

        tbl[0] = '{10,   2, 1, 100, 1, 6,   2, 10};
        tbl[1] = '{0,    5, 1, 100, 1, 0,   0, 0};
        tbl[2] = '{7,    0, 1, 100, 1, 0,   0, 0};
        tbl[3] = '{1,    3, 1, 70,  3, 3,   3, 1};
        tbl[4] = '{16,   1, 1, 50,  4, 4,   1, 16};
        tbl[5] = '{13,   3, 0, 80,  3, 12,  3, 0};
        tbl[6] = '{1023, 1, 1, 90,  2, 256, 1, 1023};
        tbl[7] = '{6,    4, 0, 60,  4, 8,   4, 0};
        for (int i = 0; i < 8; i++) run_sim(tbl[i]);

        for (int r = 0; r < 6; r++) begin
            rv.sz = $urandom_range(50, 1);
            rv.nts = $urandom_range(3, 1);
            rv.ones = 0;
            rv.rdy = $urandom_range(100, 30);
            rv.lat = $urandom_range(4, 1);
            rv.groups = rv.nts * ((rv.sz + LANES - 1) / LANES);
            rv.steps = rv.nts;
            rv.spk = 0;
            run_sim(rv);
        end

        // Back-pressure from withheld results, then abort with results in flight.
        ts0 = ts_cnt;
        size = 10'd40;
        timesteps = 10'd3;
        bus.issue_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wh_iv0", bus.issue_valid, 1);
        chk("wh_base0", bus.issue_base, 0);
        tick();
        chk("wh_iv1", bus.issue_valid, 1);
        chk("wh_base1", bus.issue_base, 4);
        tick();
        repeat (4) begin
            chk("wh_stall_iv", bus.issue_valid, 0);
            chk("wh_stall_base", bus.issue_base, 8);
            bus.issue_ready = ~bus.issue_ready;
            tick();
        end
        bus.done_valid = 1'b1;
        bus.done_spikes = 4'hF;
        bus.issue_ready = 1'b0;
        tick();
        bus.done_valid = 1'b0;
        chk("wh_resume_iv", bus.issue_valid, 1);
        repeat (3) begin
            chk("hold_iv", bus.issue_valid, 1);
            chk("hold_base", bus.issue_base, 8);
            chk("hold_mask", bus.issue_mask, 4'hF);
            tick();
        end
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        chk("wh_full_again", bus.issue_valid, 0);
        chk("wh_base3", bus.issue_base, 12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy0", busy, 1);
        chk("ab_iv", bus.issue_valid, 0);
        bus.done_valid = 1'b1;
        tick();
        bus.done_valid = 1'b0;
        chk("ab_busy1", busy, 1);
        tick();
        chk("ab_busy2", busy, 1);
        bus.done_valid = 1'b1;
        tick();
        bus.done_valid = 1'b0;
        chk("ab_idle_busy", busy, 0);
        chk("ab_finished", finished, 0);
        chk("ab_ts_pulses", ts_cnt - ts0, 0);
        chk("ab_err", err, 0);

        // Result returned with nothing outstanding.
        bus.done_valid = 1'b1;
        tick();
        bus.done_valid = 1'b0;
        chk("err_set", err, 1);
        chk("err_busy", busy, 0);
        repeat (4) tick();
        chk("err_sticky", err, 1);

        // Asynchronous reset in the middle of a simulation.
        size = 10'd40;
        timesteps = 10'd2;
        bus.issue_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 aclr = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_iv", bus.issue_valid, 0);
        chk("arst_base", bus.issue_base, 0);
        chk("arst_ts", cur_timestep, 0);
        chk("arst_err", err, 0);
        chk("arst_ts_valid", ts_valid, 0);
        chk("arst_ts_spikes", ts_spikes, 0);
        @(negedge clk);
        aclr = 1'b0;
        bus.issue_ready = 1'b0;
        tick();
        chk("arst_idle", busy, 0);
        bus.done_valid = 1'b1;
        bus.done_spikes = 4'hF;
        tick();
        bus.done_valid = 1'b0;
        chk("arst_inflight_err", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/izh_sim_seq.md
IZH_SIM_SEQ -- requirements
Module: izh_sim_seq

Interface
REQ-001 Parameter LANES, default 4: neurons issued per update request; power of two, 1..16.
REQ-002 Parameter N_W, default 10: width of neuron count and index.
REQ-003 Parameter TS_W, default 10: width of timestep count.
REQ-004 Parameter MAX_OUT, default 8: maximum outstanding issued groups; 1..255.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 aclr  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  begin simulation; sampled in IDLE or DONE only.
REQ-008 abort  input  1  cancel running simulation.
REQ-009 size  input  N_W  neuron count; captured at start.
REQ-010 timesteps  input  TS_W  timestep count; captured at start.
REQ-011 issue_valid  output  1  update request valid.
REQ-012 issue_ready  input  1  neuron pipeline accepts request.
REQ-013 issue_base  output  N_W  index of lane 0 neuron.
REQ-014 issue_mask  output  LANES  lane i active when issue_base+i < size.
REQ-015 done_valid  input  1  one group result returned from pipeline.
REQ-016 done_spikes  input  LANES  per-lane spike flags of returned group.
REQ-017 busy  output  1  high in any state except IDLE and DONE.
REQ-018 finished  output  1  high while in DONE.
REQ-019 cur_timestep  output  TS_W  timestep being simulated.
REQ-020 ts_valid / ts_spikes  output  1 / N_W+1  one-cycle pulse with total spikes of the completed timestep.
REQ-021 err  output  1  sticky: done_valid with zero outstanding.

Function
REQ-022 States IDLE, ISSUE, DRAIN, STEP, ABORT, DONE; encoding free.
REQ-023 IDLE/DONE + start: capture size, timesteps; cur_timestep=0, base=0, spike accumulator=0; go ISSUE, or DONE next cycle if size==0 or timesteps==0.
REQ-024 ISSUE: issue_valid=1 iff outstanding<MAX_OUT; request transfers on issue_valid&&issue_ready; issue_base/mask held stable while stalled.
REQ-025 On transfer: base+=LANES; if new base>=size go DRAIN.
REQ-026 Outstanding counter +1 on transfer, -1 on done_valid, unchanged when both same cycle.
REQ-027 done_valid: accumulator += popcount(done_spikes & mask of that group); mask tracked by a MAX_OUT-deep FIFO of masks, pushed on transfer, popped on done_valid.
REQ-028 DRAIN: when outstanding==0 go STEP.
REQ-029 STEP (one cycle): ts_valid=1, ts_spikes=accumulator; clear accumulator; if cur_timestep==timesteps-1 go DONE, else cur_timestep+1, base=0, go ISSUE.
REQ-030 abort in ISSUE/DRAIN/STEP: go ABORT; no further issues; ABORT goes IDLE when outstanding==0; no ts_valid, no finished.
REQ-031 abort in IDLE/DONE ignored; start outside IDLE/DONE ignored; abort wins over start.
REQ-032 done_valid with outstanding==0: ignored for counts, err set until reset.
REQ-033 Accumulator width N_W+1, saturating never needed (max size).
REQ-034 Latency: first issue_valid the cycle after start accepted; STEP one cycle after final done_valid.

Reset
REQ-035 aclr: state IDLE; issue_valid, busy, finished, ts_valid, err=0; cur_timestep, issue_base, ts_spikes, outstanding, accumulator=0; mask FIFO empty.
REQ-036 aclr mid-simulation discards all progress; in-flight pipeline results after release flag err.

Structure
REQ-037 Shared package izh_pkg holds state enum, default LANES/N_W/TS_W/MAX_OUT constants.
REQ-038 Mask FIFO is sub-module izh_mask_fifo (parametrised width LANES, depth MAX_OUT).

Verification
REQ-039 size=10, timesteps=2, LANES=4, ready=1, 1-cycle return: masks 1111,1111,0011 per step; two ts_valid pulses; finished; cur_timestep ends 1.
REQ-040 All done_spikes=1111, size=10: ts_spikes=10 each step (masked lanes excluded).
REQ-041 MAX_OUT=2, results withheld: issue_valid drops after 2 transfers; resumes one cycle after a done_valid.
REQ-042 size=0, timesteps=5: DONE one cycle after start; no issue_valid, no ts_valid.
REQ-043 abort after 2 transfers, then 2 done_valid: ABORT->IDLE after second; finished=0; no ts_valid.
REQ-044 done_valid in IDLE: err=1 and stays until aclr; issue_ready toggling keeps issue_base stable while stalled.
